// File: rtl/pio_pull_ctrl_if.sv
// pio_pull_ctrl_if: bundle between the SM execution unit / TX FIFO (master)
// and the pull controller (slave).
//   SM side     : pull_req, pull_block, pull_ifempty, out_req, autopull_en,
//                 pull_thresh, shift_count, x_reg
//   FIFO side   : fifo_empty, fifo_count, fifo_data -> ctrl; fifo_pop <- ctrl
//   OSR side    : osr_load, osr_data, osr_clear_count, stall, pull_done
// Optional (PIO_PULL_STATS_EN): stats_clr -> ctrl; stall_cycles, fifo_low <- ctrl
interface pio_pull_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 3
);
  logic              pull_req;
  logic              pull_block;
  logic              pull_ifempty;
  logic              out_req;
  logic              autopull_en;
  logic [4:0]        pull_thresh;
  logic [5:0]        shift_count;
  logic [DATA_W-1:0] x_reg;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_pop;
  logic              osr_load;
  logic [DATA_W-1:0] osr_data;
  logic              osr_clear_count;
  logic              stall;
  logic              pull_done;
`ifdef PIO_PULL_STATS_EN
  logic              stats_clr;
  logic [15:0]       stall_cycles;
  logic              fifo_low;
`endif

  modport master (
`ifdef PIO_PULL_STATS_EN
    output stats_clr,
    input  stall_cycles, fifo_low,
`endif
    output pull_req, pull_block, pull_ifempty, out_req, autopull_en,
    output pull_thresh, shift_count, x_reg,
    output fifo_empty, fifo_count, fifo_data,
    input  fifo_pop, osr_load, osr_data, osr_clear_count, stall, pull_done
  );

  modport slave (
`ifdef PIO_PULL_STATS_EN
    input  stats_clr,
    output stall_cycles, fifo_low,
`endif
    input  pull_req, pull_block, pull_ifempty, out_req, autopull_en,
    input  pull_thresh, shift_count, x_reg,
    input  fifo_empty, fifo_count, fifo_data,
    output fifo_pop, osr_load, osr_data, osr_clear_count, stall, pull_done
  );
endinterface

// File: rtl/pio_pull_ctrl.sv
// pio_pull_ctrl: sequences the TX FIFO into the state machine's OSR.
// Handles explicit PULL (blocking / non-blocking / IFEMPTY) and autopull on
// the shift-count threshold, driving pop, OSR load, stall and done strobes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pio_pull_ctrl_if.slave (see interface file for signal list)
// Optional feature macro: PIO_PULL_STATS_EN adds stall_cycles, fifo_low and
// stats_clr on the interface.
module pio_pull_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  pio_pull_ctrl_if.slave  bus
);
  localparam int unsigned THR_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              src_x_q, src_x_d;   // CAPTURE source: 1 = X, 0 = FIFO
  logic              expl_q, expl_d;     // CAPTURE kind: 1 = explicit PULL
  logic [DATA_W-1:0] osr_data_q, osr_data_d;

  logic [THR_W-1:0]  eff_thresh;
  logic              full;
  logic              pop_c, load_c, stall_c, done_c;

  // Threshold of 0 encodes a full 32-bit word.
  assign eff_thresh = (bus.pull_thresh == 5'd0) ? THR_W'(32) : THR_W'(bus.pull_thresh);
  assign full       = (bus.shift_count >= eff_thresh);

  // State register and captured transfer attributes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      src_x_q    <= 1'b0;
      expl_q     <= 1'b0;
      osr_data_q <= '0;
    end else begin
      state_q    <= state_d;
      src_x_q    <= src_x_d;
      expl_q     <= expl_d;
      osr_data_q <= osr_data_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d    = state_q;
    src_x_d    = src_x_q;
    expl_d     = expl_q;
    osr_data_d = osr_data_q;
    pop_c      = 1'b0;
    load_c     = 1'b0;
    stall_c    = 1'b0;
    done_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.pull_req) begin
          if (bus.pull_ifempty && !full) begin
            done_c = 1'b1;
          end else if (!bus.fifo_empty) begin
            pop_c   = 1'b1;
            state_d = CAPTURE;
            src_x_d = 1'b0;
            expl_d  = 1'b1;
          end else if (bus.pull_block) begin
            stall_c = 1'b1;
            state_d = STALL;
          end else begin
            // Non-blocking PULL on empty FIFO: snapshot X now.
            state_d    = CAPTURE;
            src_x_d    = 1'b1;
            expl_d     = 1'b1;
            osr_data_d = bus.x_reg;
          end
        end else if (bus.autopull_en && full) begin
          if (!bus.fifo_empty) begin
            pop_c   = 1'b1;
            state_d = CAPTURE;
            src_x_d = 1'b0;
            expl_d  = 1'b0;
          end else if (bus.out_req) begin
            stall_c = 1'b1;
          end
        end
      end

      STALL: begin
        // Abort wins over data arriving in the same cycle.
        if (!bus.pull_req) begin
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          if (!bus.fifo_empty) begin
            pop_c   = 1'b1;
            state_d = CAPTURE;
            src_x_d = 1'b0;
            expl_d  = 1'b1;
          end
        end
      end

      CAPTURE: begin
        load_c  = 1'b1;
        done_c  = expl_q;
        stall_c = expl_q | bus.out_req;
        state_d = IDLE;
        if (!src_x_q) begin
          osr_data_d = bus.fifo_data;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are forced low while reset is asserted so the bus is quiet at once.
  assign bus.fifo_pop        = rst_n & pop_c;
  assign bus.osr_load        = rst_n & load_c;
  assign bus.osr_clear_count = rst_n & load_c;
  assign bus.stall           = rst_n & stall_c;
  assign bus.pull_done       = rst_n & done_c;

  // FIFO read data is already a register; pass it through on the load cycle.
  assign bus.osr_data = (state_q == CAPTURE && !src_x_q) ? bus.fifo_data : osr_data_q;

`ifdef PIO_PULL_STATS_EN
  logic [15:0] stall_cycles_q;
  logic        fifo_low_q;

  // Saturating stall-cycle counter and registered low-water flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 16'd0;
      fifo_low_q     <= 1'b0;
    end else begin
      if (bus.stats_clr) begin
        stall_cycles_q <= 16'd0;
      end else if (stall_c && (stall_cycles_q != 16'hFFFF)) begin
        stall_cycles_q <= stall_cycles_q + 16'd1;
      end
      fifo_low_q <= (bus.fifo_count <= CNT_W'(1));
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.fifo_low     = fifo_low_q;
`else
  logic unused_fifo_count;
  assign unused_fifo_count = ^bus.fifo_count;
`endif

endmodule

// File: tb/tb_pio_pull_ctrl.sv
// tb_pio_pull_ctrl: randomized bench for pio_pull_ctrl with a transaction-level
// reference model (pending-load queue plus a queue-based TX FIFO).
module tb_pio_pull_ctrl;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pio_pull_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  pio_pull_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        pull_req;
    logic        pull_block;
    logic        pull_ifempty;
    logic        out_req;
    logic        autopull_en;
    logic [4:0]  thresh;
    logic [5:0]  sc;
    logic        push;
    logic [31:0] push_word;
    logic [31:0] x_val;
  } stim_t;

  typedef struct packed {
    logic [31:0] data;
    logic        expl;
  } ld_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] fifo_q[$];
  ld_t         load_q[$];
  bit          waiting = 0;
  bit          pop_pending = 0;
  logic [31:0] fifo_data_r = 32'd0;
  int          stall_total = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // One clock: update FIFO environment, drive inputs, check at negedge, advance model.
  task automatic step(input stim_t s);
    ld_t         ld;
    logic        e_pop, e_load, e_stall, e_done;
    logic [31:0] e_data;
    int          thr;
    bit          full;
    @(posedge clk);
    #1;
    if (pop_pending) begin
      fifo_data_r = fifo_q.pop_front();
      pop_pending = 0;
    end
    if (s.push && fifo_q.size() < 4) fifo_q.push_back(s.push_word);
    bus.pull_req     = s.pull_req;
    bus.pull_block   = s.pull_block;
    bus.pull_ifempty = s.pull_ifempty;
    bus.out_req      = s.out_req;
    bus.autopull_en  = s.autopull_en;
    bus.pull_thresh  = s.thresh;
    bus.shift_count  = s.sc;
    bus.fifo_empty   = (fifo_q.size() == 0);
    bus.fifo_count   = CNT_W'(fifo_q.size());
    bus.fifo_data    = fifo_data_r;
    if (!waiting && load_q.size() == 0) bus.x_reg = s.x_val;
    @(negedge clk);

    e_pop = 0; e_load = 0; e_stall = 0; e_done = 0; e_data = 32'd0;
    thr  = (s.thresh == 5'd0) ? 32 : int'(s.thresh);
    full = (int'(s.sc) >= thr);
    if (load_q.size() != 0) begin
      ld      = load_q.pop_front();
      e_load  = 1;
      e_data  = ld.data;
      e_done  = ld.expl;
      e_stall = ld.expl | s.out_req;
    end else if (waiting) begin
      if (!s.pull_req) begin
        waiting = 0;
      end else begin
        e_stall = 1;
        if (fifo_q.size() != 0) begin
          e_pop = 1;
          load_q.push_back('{data: fifo_q[0], expl: 1'b1});
          waiting = 0;
        end
      end
    end else if (s.pull_req) begin
      if (s.pull_ifempty && !full) begin
        e_done = 1;
      end else if (fifo_q.size() != 0) begin
        e_pop = 1;
        load_q.push_back('{data: fifo_q[0], expl: 1'b1});
      end else if (s.pull_block) begin
        e_stall = 1;
        waiting = 1;
      end else begin
        load_q.push_back('{data: bus.x_reg, expl: 1'b1});
      end
    end else if (s.autopull_en && full) begin
      if (fifo_q.size() != 0) begin
        e_pop = 1;
        load_q.push_back('{data: fifo_q[0], expl: 1'b0});
      end else if (s.out_req) begin
        e_stall = 1;
      end
    end

    check("fifo_pop", 32'(bus.fifo_pop), 32'(e_pop));
    check("osr_load", 32'(bus.osr_load), 32'(e_load));
    check("osr_clear_count", 32'(bus.osr_clear_count), 32'(e_load));
    check("stall", 32'(bus.stall), 32'(e_stall));
    check("pull_done", 32'(bus.pull_done), 32'(e_done));
    if (e_load) check("osr_data", bus.osr_data, e_data);
    if (e_stall) stall_total++;
    pop_pending = e_pop;
  endtask

  initial begin
    stim_t s;
    bus.pull_req = 0; bus.pull_block = 0; bus.pull_ifempty = 0; bus.out_req = 0;
    bus.autopull_en = 0; bus.pull_thresh = '0; bus.shift_count = '0; bus.x_reg = '0;
    bus.fifo_empty = 1; bus.fifo_count = '0; bus.fifo_data = '0;
`ifdef PIO_PULL_STATS_EN
    bus.stats_clr = 0;
`endif
    // Reset state, with a request present to prove outputs are held low.
    #3;
    bus.pull_req = 1; bus.pull_ifempty = 1; bus.pull_thresh = 5'd8;
    #9;
    check("rst_fifo_pop", 32'(bus.fifo_pop), 32'd0);
    check("rst_osr_load", 32'(bus.osr_load), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_pull_done", 32'(bus.pull_done), 32'd0);
    check("rst_osr_data", bus.osr_data, 32'd0);
    bus.pull_req = 0; bus.pull_ifempty = 0;
    #10 rst_n = 1;

    // Blocking PULL with a word already queued.
    s = idle_stim(); s.push = 1; s.push_word = 32'hDEADBEEF; step(s);
    s = idle_stim(); s.pull_req = 1; s.pull_block = 1; step(s); step(s);
    s = idle_stim(); step(s);

    // Blocking PULL on empty FIFO; data arrives after 5 stall cycles.
    s = idle_stim(); s.pull_req = 1; s.pull_block = 1;
    repeat (5) step(s);
    s.push = 1; s.push_word = 32'h12345678; step(s);
    s.push = 0; step(s);
    s = idle_stim(); step(s);

    // Non-blocking PULL on empty FIFO loads X.
    s = idle_stim(); s.pull_req = 1; s.x_val = 32'hA5A5A5A5; step(s); step(s);
    s = idle_stim(); step(s);

    // Autopull at the 32-bit boundary, then empty FIFO with OUT stalling.
    s = idle_stim(); s.push = 1; s.push_word = 32'h0BADF00D; step(s);
    s = idle_stim(); s.autopull_en = 1; s.sc = 6'd31; step(s);
    s.sc = 6'd32; step(s);
    s.sc = 6'd0; step(s);
    s.sc = 6'd32; s.out_req = 1; step(s); step(s); step(s);
    s.push = 1; s.push_word = 32'hCAFE0001; step(s);
    s.push = 0; step(s);
    s = idle_stim(); step(s);

    // IFEMPTY below and at threshold.
    s = idle_stim(); s.push = 1; s.push_word = 32'h55AA33CC; step(s);
    s = idle_stim(); s.pull_req = 1; s.pull_ifempty = 1; s.thresh = 5'd8; s.sc = 6'd4; step(s);
    s.sc = 6'd8; step(s); step(s);
    s = idle_stim(); step(s);

    // Abort a blocking stall, with data arriving on the abort cycle.
    s = idle_stim(); s.pull_req = 1; s.pull_block = 1; step(s); step(s); step(s);
    s = idle_stim(); s.push = 1; s.push_word = 32'h0000ABCD; step(s);
    s = idle_stim(); step(s);
    s.pull_req = 1; step(s); step(s);
    s = idle_stim(); step(s);

    // Randomized traffic obeying the SM hold-until-done protocol.
    for (int i = 0; i < 3000; i++) begin
      s = idle_stim();
      if (load_q.size() != 0)  s.pull_req = 1;
      else if (waiting)        s.pull_req = ($urandom_range(15, 0) != 0);
      else                     s.pull_req = ($urandom_range(3, 0) == 0);
      s.pull_block   = $urandom_range(1, 0) == 1;
      s.pull_ifempty = $urandom_range(3, 0) == 0;
      s.out_req      = $urandom_range(1, 0) == 1;
      s.autopull_en  = $urandom_range(1, 0) == 1;
      case ($urandom_range(2, 0))
        0:       s.thresh = 5'd0;
        1:       s.thresh = 5'd8;
        default: s.thresh = 5'($urandom);
      endcase
      s.sc        = 6'($urandom_range(32, 0));
      s.push      = $urandom_range(2, 0) == 0;
      s.push_word = $urandom;
      s.x_val     = $urandom;
      step(s);
    end
    s = idle_stim(); step(s); step(s);

`ifdef PIO_PULL_STATS_EN
    @(posedge clk); #1;
    check("stall_cycles", 32'(bus.stall_cycles), 32'((stall_total > 65535) ? 65535 : stall_total));
`endif

    // Reset asserted in the middle of CAPTURE.
    while (load_q.size() != 0 || waiting) begin
      s = idle_stim(); step(s);
    end
    s = idle_stim(); s.push = 1; s.push_word = 32'h77778888; step(s);
    s = idle_stim(); s.pull_req = 1; s.pull_block = 1; step(s);
    @(posedge clk); #1;
    if (pop_pending) begin
      fifo_data_r = fifo_q.pop_front();
      pop_pending = 0;
    end
    bus.fifo_data = fifo_data_r;
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.out_req = 1;
    #1;
    check("cap_osr_load", 32'(bus.osr_load), 32'd1);
    rst_n = 0;
    #1;
    check("rstcap_osr_load", 32'(bus.osr_load), 32'd0);
    check("rstcap_osr_clear", 32'(bus.osr_clear_count), 32'd0);
    check("rstcap_stall", 32'(bus.stall), 32'd0);
    check("rstcap_pull_done", 32'(bus.pull_done), 32'd0);
    check("rstcap_fifo_pop", 32'(bus.fifo_pop), 32'd0);
    check("rstcap_osr_data", bus.osr_data, 32'd0);
    load_q.delete();
    waiting = 0;
    @(negedge clk);
    rst_n = 1;
    s = idle_stim(); step(s); step(s);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pio_pull_ctrl.md
Name: pio_pull_ctrl

Overview:
- Per-state-machine controller that sequences the 4-deep, 32-bit TX FIFO into the state machine's output shift register (OSR).
- Executes explicit PULL (blocking, non-blocking, IFEMPTY) and autopull on a shift-count threshold.
- Drives the FIFO pop strobe, OSR load, SM stall and instruction-done pulses.
- Sits between the TX FIFO instance and the SM execution unit.

Parameters:
- DATA_W, 32, FIFO word and OSR width.
- CNT_W, 3, width of the FIFO occupancy input (0..4).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- pull_req  in  1  SM is executing a PULL; held high until done or abort.
- pull_block  in  1  PULL is blocking; sampled with pull_req.
- pull_ifempty  in  1  PULL IFEMPTY variant.
- out_req  in  1  SM is executing an OUT this cycle.
- autopull_en  in  1  autopull enable.
- pull_thresh  in  5  autopull/IFEMPTY threshold; 0 encodes 32.
- shift_count  in  6  bits already shifted out of the OSR (0..32).
- x_reg  in  DATA_W  scratch X; loaded on a non-blocking PULL when the FIFO is empty.
- fifo_empty  in  1  TX FIFO empty flag.
- fifo_count  in  CNT_W  TX FIFO occupancy; used only by the optional feature.
- fifo_data  in  DATA_W  TX FIFO registered read data; valid the cycle after a pop.
- fifo_pop  out  1  FIFO pop strobe (combinational from state and inputs).
- osr_load  out  1  one-cycle OSR load strobe.
- osr_data  out  DATA_W  word to load into the OSR (registered).
- osr_clear_count  out  1  resets the SM's shift_count; coincident with osr_load.
- stall  out  1  SM must not advance PC.
- pull_done  out  1  one-cycle pulse; the explicit PULL has completed.

Behaviour:
- Reset (async, rst_n=0): state IDLE; fifo_pop, osr_load, osr_clear_count, stall, pull_done = 0; osr_data = 0.
- eff_thresh = (pull_thresh == 0) ? 32 : pull_thresh, held at 6 bits. full = shift_count >= eff_thresh.
- States: IDLE, STALL, CAPTURE. CAPTURE records the source (FIFO or X) and the kind (explicit or auto).

IDLE, in priority order:
1. pull_req && pull_ifempty && !full -> pull_done=1 the same cycle; no pop, no load; stay IDLE.
2. pull_req && !fifo_empty -> fifo_pop=1; go to CAPTURE(FIFO, explicit).
3. pull_req && fifo_empty && pull_block -> go to STALL; stall=1 the same cycle.
4. pull_req && fifo_empty && !pull_block -> go to CAPTURE(X, explicit); no pop.
5. !pull_req && autopull_en && full && !fifo_empty -> fifo_pop=1; go to CAPTURE(FIFO, auto).
6. !pull_req && autopull_en && full && fifo_empty && out_req -> stall=1; stay IDLE. Retried every cycle.

STALL:
- stall=1 while fifo_empty.
- When !fifo_empty: fifo_pop=1, stall=1 this cycle, go to CAPTURE(FIFO, explicit).
- pull_req deasserted (SM disabled or restarted): abort to IDLE the next cycle; no pop; stall drops the same cycle.

CAPTURE (exactly one cycle, always followed by IDLE):
- osr_load=1, osr_clear_count=1, osr_data = fifo_data or x_reg.
- pull_done=1 only for explicit pulls.
- stall=1 during CAPTURE for explicit pulls; also for auto pulls when out_req=1.
- No new pop is issued in CAPTURE; this guarantees at most one pop per load.

Latency and boundary rules:
- Latency: pop to OSR load is exactly 1 cycle. Non-empty blocking PULL completes 1 cycle after acceptance.
- Explicit PULL takes priority over autopull in the same cycle; no double pop.
- FIFO goes non-empty in the same cycle pull_req drops while in STALL: abort wins, no pop.
- Pop is never issued when fifo_empty=1. FIFO wrap and occupancy are the FIFO's concern.
- Reset mid-CAPTURE: the popped word is discarded; the FIFO pointer has already advanced (accepted loss).

Optional Feature:
- Macro: PIO_PULL_STATS_EN.
- Defined: adds output stall_cycles [15:0] and input stats_clr [1].
  - Counts every cycle with stall=1; saturates at 16'hFFFF.
  - stats_clr has priority and zeroes the counter synchronously; async reset to 0.
  - Adds output fifo_low [1]: registered (fifo_count <= 1).
- Undefined: no extra ports or logic; behaviour above is unchanged.

Test Plan:
- FIFO holds 32'hDEADBEEF, pull_req=1, pull_block=1 -> fifo_pop=1 in cycle 0; cycle 1: osr_load=1, osr_data=32'hDEADBEEF, pull_done=1, stall=1; cycle 2: IDLE, all strobes 0.
- FIFO empty, blocking PULL; push 32'h12345678 after 5 cycles -> stall=1 for 5 cycles plus the pop and capture cycles; osr_data=32'h12345678; exactly one fifo_pop.
- FIFO empty, pull_block=0, x_reg=32'hA5A5A5A5 -> no pop; next cycle osr_load=1, osr_data=32'hA5A5A5A5, pull_done=1.
- autopull_en=1, pull_thresh=0, shift_count=31 then 32, FIFO non-empty -> no pop at 31; pop at 32; load with pull_done=0. Repeat with FIFO empty and out_req=1 -> stall=1 until data arrives.
- pull_ifempty=1, pull_thresh=8, shift_count=4 -> pull_done=1 the same cycle, no pop. With shift_count=8 -> behaves as a normal PULL.
- Blocking-PULL stall: drop pull_req -> IDLE, no pop. Separately, assert rst_n=0 during CAPTURE -> all outputs 0 immediately. With PIO_PULL_STATS_EN: stall_cycles matches the stall count; saturates at 16'hFFFF.
